dot_product_acc: RTL and testbench



---
 rtl/dnn_pkg.sv | 16 +
 rtl/sat_narrow.sv | 25 ++
 rtl/dot_product_acc.sv | 120 ++++++++++++
 tb/tb_dot_product_acc.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Shared numeric constants for the PE datapath (dot product, ReLU, requantise).
// Also provides the minimum accumulator width needed to sum a vector without overflow.
package dnn_pkg;

  localparam int INT8_W  = 8;
  localparam int ACC16_W = 16;

  localparam logic signed [ACC16_W-1:0] INT16_MAX = 16'sh7FFF;
  localparam logic signed [ACC16_W-1:0] INT16_MIN = 16'sh8000;

  // Product bits, plus growth over vec_len terms, plus headroom for the bias.
  function automatic int min_acc_width(input int w_in, input int vec_len);
    return (32'sd2 * w_in) + $clog2(vec_len) + 32'sd2;
  endfunction

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits.
// Shared by the dot-product output and the requantisation stage.
module sat_narrow #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  localparam logic [IN_W-1:0] MAX_IN = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [IN_W-1:0] MIN_IN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // clamp to the representable OUT_W signed range
  always_comb begin
    if ($signed(din) > $signed(MAX_IN)) begin
      dout = MAX_IN[OUT_W-1:0];
    end else if ($signed(din) < $signed(MIN_IN)) begin
      dout = MIN_IN[OUT_W-1:0];
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/dot_product_acc.sv
// Two-stage int8 multiply-accumulate over VEC_LEN elements plus bias.
// Emits one saturated WIDTH_OUT result with a single-cycle valid pulse per vector.
module dot_product_acc
  import dnn_pkg::*;
#(
  parameter int WIDTH_IN  = INT8_W,
  parameter int WIDTH_OUT = ACC16_W,
  parameter int VEC_LEN   = 9,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [WIDTH_IN-1:0]  act_in,
  input  logic [WIDTH_IN-1:0]  wgt_in,
  input  logic [WIDTH_OUT-1:0] bias_in,
  output logic [WIDTH_OUT-1:0] data_out,
  output logic                 valid_out,
  output logic                 busy
);

  localparam int PROD_W = 2 * WIDTH_IN;
  localparam int CNT_W  = $clog2(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  if (ACC_WIDTH < min_acc_width(WIDTH_IN, VEC_LEN)) begin : g_acc_width_check
    $error("dot_product_acc: ACC_WIDTH too small for WIDTH_IN/VEC_LEN");
  end

  logic [CNT_W-1:0]     cnt_r;
  logic                 p_valid_r;
  logic                 p_first_r;
  logic                 p_last_r;
  logic [PROD_W-1:0]    prod_r;
  logic [WIDTH_OUT-1:0] bias_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic                 open_r;

  logic [PROD_W-1:0]    prod_s;
  logic [ACC_WIDTH-1:0] prod_ext_s;
  logic [ACC_WIDTH-1:0] bias_ext_s;
  logic [ACC_WIDTH-1:0] acc_next_s;
  logic [WIDTH_OUT-1:0] sat_s;

  // Low PROD_W bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH_IN{act_in[WIDTH_IN-1]}}, act_in} *
                  {{WIDTH_IN{wgt_in[WIDTH_IN-1]}}, wgt_in};

  // element counter, wraps after the last element of a vector
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (valid_in) begin
      cnt_r <= (cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
    end
  end

  // stage 1: register product, position flags and (for element 0) the bias
  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_r <= 1'b0;
      p_first_r <= 1'b0;
      p_last_r  <= 1'b0;
      prod_r    <= {PROD_W{1'b0}};
      bias_r    <= {WIDTH_OUT{1'b0}};
    end else begin
      p_valid_r <= valid_in;
      if (valid_in) begin
        prod_r    <= prod_s;
        p_first_r <= (cnt_r == {CNT_W{1'b0}});
        p_last_r  <= (cnt_r == CNT_LAST);
        if (cnt_r == {CNT_W{1'b0}}) begin
          bias_r <= bias_in;
        end
      end
    end
  end

  // next accumulator value; element 0 restarts from the bias, so no clear cycle is needed
  always_comb begin
    prod_ext_s = {{(ACC_WIDTH-PROD_W){prod_r[PROD_W-1]}}, prod_r};
    bias_ext_s = {{(ACC_WIDTH-WIDTH_OUT){bias_r[WIDTH_OUT-1]}}, bias_r};
    if (p_first_r) begin
      acc_next_s = bias_ext_s + prod_ext_s;
    end else begin
      acc_next_s = acc_r + prod_ext_s;
    end
  end

  sat_narrow #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (WIDTH_OUT)
  ) u_sat (
    .din  (acc_next_s),
    .dout (sat_s)
  );

  // stage 2: accumulate and publish the clamped sum on the last element
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {ACC_WIDTH{1'b0}};
      open_r    <= 1'b0;
      data_out  <= {WIDTH_OUT{1'b0}};
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (p_valid_r) begin
        acc_r  <= acc_next_s;
        open_r <= ~p_last_r;
        if (p_last_r) begin
          data_out  <= sat_s;
          valid_out <= 1'b1;
        end
      end
    end
  end

  assign busy = (cnt_r != {CNT_W{1'b0}}) | p_valid_r | open_r;

endmodule

// File: tb/tb_dot_product_acc.sv
// Self-checking bench for dot_product_acc: directed scenarios plus randomized vectors
// compared against an arithmetic reference model (bias + sum of products, clamped).
module tb_dot_product_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [7:0]  act_in;
  logic [7:0]  wgt_in;
  logic [15:0] bias_in;
  logic [15:0] data_out;
  logic        valid_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int res_q[$];
  int res_cyc_q[$];

  dot_product_acc dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .act_in    (act_in),
    .wgt_in    (wgt_in),
    .bias_in   (bias_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      res_q.push_back(int'($signed(data_out)));
      res_cyc_q.push_back(cyc);
    end
  end

  function automatic int ref_dot(input int b, input int a[9], input int w[9]);
    longint s = b;
    for (int i = 0; i < 9; i++) s += longint'(a[i]) * longint'(w[i]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic drive_elem(input int a, input int w, input int b);
    valid_in = 1'b1;
    act_in   = a[7:0];
    wgt_in   = w[7:0];
    bias_in  = b[15:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // later elements carry random bias values that must be ignored
  task automatic send_vec(input int b, input int a[9], input int w[9], input int gap_max);
    for (int i = 0; i < 9; i++) begin
      drive_elem(a[i], w[i], (i == 0) ? b : int'($urandom));
      if (gap_max > 0 && i < 8) idle(int'($urandom_range(gap_max, 0)));
    end
  endtask

  task automatic clear_results();
    res_q.delete();
    res_cyc_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b1;
    act_in = 8'd5; wgt_in = 8'd5; bias_in = 16'd7;
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_out !== 16'd0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: data_out=%0d valid_out=%b busy=%b, expected 0/0/0", data_out, valid_out, busy);
    end
    rst = 1'b0;
    valid_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ones_latency();
    clear_results();
    for (int i = 0; i < 9; i++) drive_elem(1, 1, 0);
    valid_in = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_early: valid_out=%b one edge after last element, expected 0", valid_out);
    end
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b1 || data_out !== 16'd9) begin
      n_fail++;
      $display("FAIL ones_pulse: valid_out=%b data_out=%0d, expected 1/9", valid_out, data_out);
    end
    @(negedge clk);
    n_checks++;
    if (valid_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ones_after: valid_out=%b busy=%b, expected 0/0", valid_out, busy);
    end
    idle(4);
    n_checks++;
    if (res_q.size() != 1) begin
      n_fail++;
      $display("FAIL ones_count: %0d pulses, expected 1", res_q.size());
    end
  endtask

  // table rows: bias, act, wgt applied to all nine elements
  task automatic test_saturation_and_bias();
    int tb_b[4] = '{0, 0, 100, -20};
    int tb_a[4] = '{127, -128, 2, 0};
    int tb_w[4] = '{127, 127, -3, 77};
    int a[9], w[9], exp_v;
    for (int t = 0; t < 4; t++) begin
      clear_results();
      for (int i = 0; i < 9; i++) begin a[i] = tb_a[t]; w[i] = tb_w[t]; end
      exp_v = ref_dot(tb_b[t], a, w);
      send_vec(tb_b[t], a, w, 0);
      idle(5);
      n_checks++;
      if (res_q.size() != 1 || res_q[0] != exp_v) begin
        n_fail++;
        $display("FAIL directed_%0d: pulses=%0d value=%0d, expected 1 pulse of %0d",
                 t, res_q.size(), (res_q.size() > 0) ? res_q[0] : 0, exp_v);
      end
    end
  endtask

  task automatic test_gaps();
    int pulses = 0;
    clear_results();
    for (int i = 1; i <= 9; i++) begin
      drive_elem(i, 1, 0);
      if (i < 9) begin
        valid_in = 1'b0;
        for (int g = int'($urandom_range(5, 0)); g > 0; g--) begin
          @(negedge clk);
          n_checks++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL gap_busy: busy=%b during gap after element %0d, expected 1", busy, i);
          end
        end
      end
    end
    valid_in = 1'b0;
    for (int k = 0; k < 10 && pulses == 0; k++) begin
      if (valid_out === 1'b1) pulses++;
      else @(negedge clk);
    end
    n_checks++;
    if (pulses == 0) begin
      n_fail++;
      $display("FAIL gap_timeout: no valid_out within 10 cycles, expected a pulse");
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_busy_drop: busy=%b after pulse, expected 0", busy);
    end
    idle(3);
    n_checks++;
    if (res_q.size() != 1 || res_q[0] != 45) begin
      n_fail++;
      $display("FAIL gap_result: pulses=%0d value=%0d, expected 1 pulse of 45",
               res_q.size(), (res_q.size() > 0) ? res_q[0] : 0);
    end
  endtask

  task automatic test_back_to_back();
    int a1[9], w1[9], a2[9], w2[9];
    clear_results();
    for (int i = 0; i < 9; i++) begin a1[i] = 1; w1[i] = 1; a2[i] = 2; w2[i] = 3; end
    send_vec(0, a1, w1, 0);
    send_vec(0, a2, w2, 0);
    idle(5);
    n_checks++;
    if (res_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: %0d pulses, expected 2", res_q.size());
    end else begin
      n_checks++;
      if (res_q[0] != 9 || res_q[1] != 54) begin
        n_fail++;
        $display("FAIL b2b_values: got %0d,%0d, expected 9,54", res_q[0], res_q[1]);
      end
      n_checks++;
      if (res_cyc_q[1] - res_cyc_q[0] != 9) begin
        n_fail++;
        $display("FAIL b2b_spacing: pulses %0d cycles apart, expected 9", res_cyc_q[1] - res_cyc_q[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int a[9], w[9];
    clear_results();
    for (int i = 0; i < 5; i++) drive_elem(1, 1, 0);
    rst = 1'b1;
    drive_elem(3, 3, 0);
    rst = 1'b0;
    valid_in = 1'b0;
    n_checks++;
    if (data_out !== 16'd0 || valid_out !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: data_out=%0d valid_out=%b busy=%b, expected 0/0/0", data_out, valid_out, busy);
    end
    idle(1);
    for (int i = 0; i < 9; i++) begin a[i] = 1; w[i] = 1; end
    send_vec(0, a, w, 0);
    idle(5);
    n_checks++;
    if (res_q.size() != 1 || res_q[0] != 9) begin
      n_fail++;
      $display("FAIL midrst_result: pulses=%0d value=%0d, expected 1 pulse of 9",
               res_q.size(), (res_q.size() > 0) ? res_q[0] : 0);
    end
  endtask

  task automatic test_random();
    int a[9], w[9], b, exp_q[$];
    clear_results();
    for (int v = 0; v < 12; v++) begin
      b = int'($urandom_range(65535, 0)) - 32768;
      for (int i = 0; i < 9; i++) begin
        a[i] = int'($urandom_range(255, 0)) - 128;
        w[i] = int'($urandom_range(255, 0)) - 128;
      end
      exp_q.push_back(ref_dot(b, a, w));
      send_vec(b, a, w, int'($urandom_range(2, 0)));
    end
    idle(6);
    n_checks++;
    if (res_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: %0d pulses, expected %0d", res_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (res_q[k] != exp_q[k]) begin
          n_fail++;
          $display("FAIL rand_vec%0d: data_out=%0d, expected %0d", k, res_q[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    act_in = 8'd0;
    wgt_in = 8'd0;
    bias_in = 16'd0;
    @(negedge clk);
    test_reset();
    test_ones_latency();
    test_saturation_and_bias();
    test_gaps();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
